// File: rtl/bcd2bin_seq_if.sv
// Start/busy/done handshake and data bus for the sequential BCD-to-binary converter.
interface bcd2bin_seq_if #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 16
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BIN_W-1:0]      bin_out;

    modport master (
        output start, bcd_in,
        input  busy, done, err, bin_out
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, err, bin_out
    );
endinterface

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble): one shift/correct
// step per clock, BIN_W steps per conversion, flags digits above 9.
module bcd2bin_seq #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    bcd2bin_seq_if.slave   bus
);
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned WORK_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W  = $clog2(BIN_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [WORK_W-1:0]   work;
    logic [WORK_W-1:0]   shifted_c;
    logic [WORK_W-1:0]   work_nxt_c;
    logic [CNT_W-1:0]    count;
    logic                err_pend;
    logic                bad_digit_c;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [BIN_W-1:0]    bin_q;

    // One conversion step: shift right, then pull every BCD digit >= 8 down by 3
    always_comb begin
        shifted_c  = {1'b0, work[WORK_W-1:1]};
        work_nxt_c = shifted_c;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (shifted_c[BIN_W + 4*d + 3]) begin
                work_nxt_c[BIN_W + 4*d +: 4] = shifted_c[BIN_W + 4*d +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        bad_digit_c = 1'b0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (bus.bcd_in[4*d +: 4] > 4'd9) begin
                bad_digit_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            work     <= '0;
            count    <= '0;
            err_pend <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            bin_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        work     <= {bus.bcd_in, BIN_W'(0)};
                        count    <= '0;
                        err_pend <= bad_digit_c;
                        busy_q   <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    work  <= work_nxt_c;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(BIN_W - 1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        err_q  <= err_pend;
                        bin_q  <= err_pend ? '0 : work_nxt_c[BIN_W-1:0];
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.bin_out = bin_q;
endmodule
